// File: rtl/qp_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : qp_mem_arbiter_if
// Brief    : Requester, SRAM-port and read-return bundle for qp_mem_arbiter.
// Revision : 1.0
// ============================================================================
interface qp_mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 55
);
    logic              core_req;
    logic              core_we;
    logic              core_lock;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              wbs_req;
    logic              wbs_we;
    logic [ADDR_W-1:0] wbs_addr;
    logic [DATA_W-1:0] wbs_wdata;
    logic              wbs_gnt;
    logic              wbs_rvalid;
    logic [DATA_W-1:0] wbs_rdata;

    logic              mem_csb0;
    logic              mem_web0;
    logic [ADDR_W-1:0] mem_addr0;
    logic [DATA_W-1:0] mem_wpatch0;
    logic [DATA_W-1:0] mem_rpatch0;

    // master: the two requesters plus the SRAM read-data source; slave: the arbiter
    modport master (
        output core_req, core_we, core_lock, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output wbs_req, wbs_we, wbs_addr, wbs_wdata,
        input  wbs_gnt, wbs_rvalid, wbs_rdata,
        input  mem_csb0, mem_web0, mem_addr0, mem_wpatch0,
        output mem_rpatch0
    );

    modport slave (
        input  core_req, core_we, core_lock, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  wbs_req, wbs_we, wbs_addr, wbs_wdata,
        output wbs_gnt, wbs_rvalid, wbs_rdata,
        output mem_csb0, mem_web0, mem_addr0, mem_wpatch0,
        input  mem_rpatch0
    );
endinterface
`default_nettype wire

// File: rtl/qp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qp_mem_arbiter
// Brief    : Core-priority arbiter for the query-patch SRAM with wishbone
//            starvation guard and debug lockout. Optional perf counters are
//            enabled by defining QP_ARB_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module qp_mem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 55,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 4
) (
    input  wire         wb_clk_i,
    input  wire         wb_rst_i,
    input  wire         wbs_debug,
    qp_mem_arbiter_if.slave bus
`ifdef QP_ARB_PERF_CNT_EN
    ,
    input  wire         perf_clr,
    output logic [15:0] perf_conflict,
    output logic [15:0] perf_forced
`endif
);
    localparam logic [1:0]       c_CORE_PRI  = 2'd0;
    localparam logic [1:0]       c_CORE_LOCK = 2'd1;
    localparam logic [1:0]       c_WBS_FORCE = 2'd2;
    localparam logic [CNT_W-1:0] c_MAX_WAIT  = CNT_W'(MAX_WAIT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             w_core_gnt;
    logic             w_wbs_gnt;
    logic             r_core_rvalid;
    logic             r_wbs_rvalid;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= c_CORE_PRI;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_CORE_PRI:  if (w_core_gnt && bus.core_lock) w_state_next = c_CORE_LOCK;
            c_CORE_LOCK: if (wbs_debug || !(w_core_gnt && bus.core_lock)) w_state_next = c_CORE_PRI;
            c_WBS_FORCE: w_state_next = c_CORE_PRI;
            default:     w_state_next = c_CORE_PRI;
        endcase
        // The counter only reaches the limit on a denied cycle, so forcing wins over locking
        if (w_wait_cnt_next == c_MAX_WAIT) w_state_next = c_WBS_FORCE;
    end

    always_comb begin
        w_core_gnt = 1'b0;
        w_wbs_gnt  = 1'b0;
        if (!wb_rst_i) begin
            case (r_state)
                c_CORE_PRI: begin
                    if (wbs_debug)         w_wbs_gnt  = bus.wbs_req;
                    else if (bus.core_req) w_core_gnt = 1'b1;
                    else                   w_wbs_gnt  = bus.wbs_req;
                end
                // Debug releases the lock in the same cycle it appears
                c_CORE_LOCK: begin
                    if (wbs_debug) w_wbs_gnt  = bus.wbs_req;
                    else           w_core_gnt = bus.core_req;
                end
                c_WBS_FORCE: w_wbs_gnt = bus.wbs_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if (w_wbs_gnt || !bus.wbs_req) begin
            w_wait_cnt_next = '0;
        end else if (!wbs_debug && (r_wait_cnt != c_MAX_WAIT)) begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wait_cnt    <= '0;
            r_core_rvalid <= 1'b0;
            r_wbs_rvalid  <= 1'b0;
        end else begin
            r_wait_cnt    <= w_wait_cnt_next;
            r_core_rvalid <= w_core_gnt && !bus.core_we;
            r_wbs_rvalid  <= w_wbs_gnt && !bus.wbs_we;
        end
    end

    always_comb begin
        bus.mem_csb0    = 1'b1;
        bus.mem_web0    = 1'b1;
        bus.mem_addr0   = '0;
        bus.mem_wpatch0 = '0;
        if (w_core_gnt) begin
            bus.mem_csb0    = 1'b0;
            bus.mem_web0    = ~bus.core_we;
            bus.mem_addr0   = bus.core_addr;
            bus.mem_wpatch0 = bus.core_wdata;
        end else if (w_wbs_gnt) begin
            bus.mem_csb0    = 1'b0;
            bus.mem_web0    = ~bus.wbs_we;
            bus.mem_addr0   = bus.wbs_addr;
            bus.mem_wpatch0 = bus.wbs_wdata;
        end
    end

    assign bus.core_gnt    = w_core_gnt;
    assign bus.wbs_gnt     = w_wbs_gnt;
    assign bus.core_rvalid = r_core_rvalid;
    assign bus.wbs_rvalid  = r_wbs_rvalid;
    assign bus.core_rdata  = r_core_rvalid ? bus.mem_rpatch0 : '0;
    assign bus.wbs_rdata   = r_wbs_rvalid  ? bus.mem_rpatch0 : '0;

`ifdef QP_ARB_PERF_CNT_EN
    logic w_forced_entry;
    assign w_forced_entry = (w_state_next == c_WBS_FORCE) && (r_state != c_WBS_FORCE);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            perf_conflict <= '0;
            perf_forced   <= '0;
        end else if (perf_clr) begin
            perf_conflict <= '0;
            perf_forced   <= '0;
        end else begin
            if (bus.core_req && bus.wbs_req && (perf_conflict != 16'hFFFF))
                perf_conflict <= perf_conflict + 16'd1;
            if (w_forced_entry && (perf_forced != 16'hFFFF))
                perf_forced <= perf_forced + 16'd1;
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_qp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qp_mem_arbiter
// Brief    : Directed vector table plus multi-cycle sequences for qp_mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_qp_mem_arbiter;
    localparam logic [54:0] c_ONES = {55{1'b1}};

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    logic wbs_debug = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    qp_mem_arbiter_if #(.ADDR_W(9), .DATA_W(55)) bus ();

`ifdef QP_ARB_PERF_CNT_EN
    logic        perf_clr = 1'b0;
    logic [15:0] perf_conflict;
    logic [15:0] perf_forced;
`endif

    qp_mem_arbiter #(.ADDR_W(9), .DATA_W(55), .MAX_WAIT(8), .CNT_W(4)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_debug (wbs_debug),
        .bus       (bus)
`ifdef QP_ARB_PERF_CNT_EN
        ,
        .perf_clr      (perf_clr),
        .perf_conflict (perf_conflict),
        .perf_forced   (perf_forced)
`endif
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic rst, dbg, c_req, c_we, c_lock;
        logic [8:0] c_addr; logic [54:0] c_wdata;
        logic w_req, w_we;
        logic [8:0] w_addr; logic [54:0] w_wdata;
        logic [54:0] rpatch;
        logic e_cg, e_wg, e_csb, e_web;
        logic [8:0] e_addr; logic [54:0] e_wpatch;
        logic e_crv, e_wrv;
        logic [54:0] e_crd, e_wrd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        wb_rst_i        = v.rst;
        wbs_debug       = v.dbg;
        bus.core_req    = v.c_req;
        bus.core_we     = v.c_we;
        bus.core_lock   = v.c_lock;
        bus.core_addr   = v.c_addr;
        bus.core_wdata  = v.c_wdata;
        bus.wbs_req     = v.w_req;
        bus.wbs_we      = v.w_we;
        bus.wbs_addr    = v.w_addr;
        bus.wbs_wdata   = v.w_wdata;
        bus.mem_rpatch0 = v.rpatch;
    endtask

    task automatic idle();
        wbs_debug = 1'b0;
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_lock = 1'b0;
        bus.core_addr = '0; bus.core_wdata = '0;
        bus.wbs_req = 1'b0; bus.wbs_we = 1'b0; bus.wbs_addr = '0; bus.wbs_wdata = '0;
        bus.mem_rpatch0 = '0;
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // One starvation window: 8 core beats, then the forced wishbone beat
    task automatic starve_round(input int r);
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h001;
        bus.wbs_req  = 1'b1; bus.wbs_we  = 1'b0; bus.wbs_addr  = 9'h002;
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk_i);
            chk($sformatf("starve%0d c%0d core_gnt", r, i), 64'(bus.core_gnt), 64'd1);
            chk($sformatf("starve%0d c%0d wbs_gnt", r, i), 64'(bus.wbs_gnt), 64'd0);
            tick();
        end
        @(negedge wb_clk_i);
        chk($sformatf("starve%0d force wbs_gnt", r), 64'(bus.wbs_gnt), 64'd1);
        chk($sformatf("starve%0d force core_gnt", r), 64'(bus.core_gnt), 64'd0);
        chk($sformatf("starve%0d force addr", r), 64'(bus.mem_addr0), 64'h002);
        tick();
        bus.wbs_req = 1'b0;
        @(negedge wb_clk_i);
        chk($sformatf("starve%0d resume core_gnt", r), 64'(bus.core_gnt), 64'd1);
        tick();
    endtask

    initial begin
        vecs[0] = '{1,0,1,0,0,9'h05,0, 1,0,9'h0A,0, 0,         0,0,1,1,9'h000,0,      0,0,0,0};
        vecs[1] = '{0,0,1,0,0,9'h05,0, 0,0,9'h00,0, 0,         1,0,0,1,9'h005,0,      0,0,0,0};
        vecs[2] = '{0,0,0,0,0,9'h00,0, 0,0,9'h00,0, 55'h1234,  0,0,1,1,9'h000,0,      1,0,55'h1234,0};
        vecs[3] = '{0,0,0,0,0,9'h00,0, 1,0,9'h0A,0, 55'h777,   0,1,0,1,9'h00A,0,      0,0,0,0};
        vecs[4] = '{0,0,1,1,0,9'h33,55'hABC, 0,0,9'h00,0, 55'h999, 1,0,0,0,9'h033,55'hABC, 0,1,0,55'h999};
        vecs[5] = '{0,0,0,0,0,9'h00,0, 0,0,9'h00,0, 55'h555,   0,0,1,1,9'h000,0,      0,0,0,0};
        vecs[6] = '{0,0,1,0,0,9'h10,55'h1, 1,1,9'h20,55'h2, 0, 1,0,0,1,9'h010,55'h1,  0,0,0,0};
        vecs[7] = '{0,1,1,0,0,9'h10,55'h1, 1,1,9'h1FF,c_ONES, 55'h42, 0,1,0,0,9'h1FF,c_ONES, 1,0,55'h42,0};
        vecs[8] = '{0,1,1,0,0,9'h10,55'h1, 0,0,9'h00,0, 55'h66, 0,0,1,1,9'h000,0,     0,0,0,0};
        vecs[9] = '{0,0,0,0,0,9'h00,0, 0,0,9'h00,0, 55'h77,    0,0,1,1,9'h000,0,      0,0,0,0};

        idle();
        tick();
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
            @(negedge wb_clk_i);
            chk($sformatf("v%0d core_gnt", i),    64'(bus.core_gnt),    64'(vecs[i].e_cg));
            chk($sformatf("v%0d wbs_gnt", i),     64'(bus.wbs_gnt),     64'(vecs[i].e_wg));
            chk($sformatf("v%0d csb0", i),        64'(bus.mem_csb0),    64'(vecs[i].e_csb));
            chk($sformatf("v%0d web0", i),        64'(bus.mem_web0),    64'(vecs[i].e_web));
            chk($sformatf("v%0d addr0", i),       64'(bus.mem_addr0),   64'(vecs[i].e_addr));
            chk($sformatf("v%0d wpatch0", i),     64'(bus.mem_wpatch0), 64'(vecs[i].e_wpatch));
            chk($sformatf("v%0d core_rvalid", i), 64'(bus.core_rvalid), 64'(vecs[i].e_crv));
            chk($sformatf("v%0d wbs_rvalid", i),  64'(bus.wbs_rvalid),  64'(vecs[i].e_wrv));
            chk($sformatf("v%0d core_rdata", i),  64'(bus.core_rdata),  64'(vecs[i].e_crd));
            chk($sformatf("v%0d wbs_rdata", i),   64'(bus.wbs_rdata),   64'(vecs[i].e_wrd));
            tick();
        end

        // Starvation guard, twice: the second round also proves the counter restarted
        idle();
        starve_round(0);
        idle();
        starve_round(1);
        idle();
        tick();

        // Lock: three locked beats, one bubble, then wishbone gets in
        bus.wbs_req = 1'b1; bus.wbs_addr = 9'h040;
        bus.core_req = 1'b1; bus.core_lock = 1'b1; bus.core_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            chk($sformatf("lock b%0d core_gnt", i), 64'(bus.core_gnt), 64'd1);
            chk($sformatf("lock b%0d wbs_gnt", i), 64'(bus.wbs_gnt), 64'd0);
            tick();
        end
        bus.core_req = 1'b0; bus.core_lock = 1'b0;
        @(negedge wb_clk_i);
        chk("lock bubble wbs_gnt", 64'(bus.wbs_gnt), 64'd0);
        chk("lock bubble csb0", 64'(bus.mem_csb0), 64'd1);
        tick();
        @(negedge wb_clk_i);
        chk("lock release wbs_gnt", 64'(bus.wbs_gnt), 64'd1);
        tick();
        idle();
        tick();

        // Debug rising while locked drops the lock at once
        bus.core_req = 1'b1; bus.core_lock = 1'b1; bus.core_we = 1'b1;
        @(negedge wb_clk_i);
        chk("dbglock enter core_gnt", 64'(bus.core_gnt), 64'd1);
        tick();
        wbs_debug = 1'b1; bus.wbs_req = 1'b1;
        @(negedge wb_clk_i);
        chk("dbglock wbs_gnt", 64'(bus.wbs_gnt), 64'd1);
        chk("dbglock core_gnt", 64'(bus.core_gnt), 64'd0);
        tick();
        wbs_debug = 1'b0; bus.core_lock = 1'b0; bus.wbs_req = 1'b0;
        @(negedge wb_clk_i);
        chk("dbglock after core_gnt", 64'(bus.core_gnt), 64'd1);
        tick();
        idle();
        tick();

        // Reset during a read in flight: rvalid must never appear
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_lock = 1'b1; bus.core_addr = 9'h0C;
        @(negedge wb_clk_i);
        chk("rstrd core_gnt", 64'(bus.core_gnt), 64'd1);
        wb_rst_i = 1'b1;
        #1;
        chk("rstrd gnt in reset", 64'(bus.core_gnt), 64'd0);
        tick();
        @(negedge wb_clk_i);
        chk("rstrd core_rvalid", 64'(bus.core_rvalid), 64'd0);
        chk("rstrd csb0", 64'(bus.mem_csb0), 64'd1);
        tick();
        wb_rst_i = 1'b0;
        bus.core_req = 1'b0; bus.core_lock = 1'b0;
        bus.wbs_req = 1'b1; bus.wbs_we = 1'b0; bus.wbs_addr = 9'h0D;
        @(negedge wb_clk_i);
        chk("rstrd post wbs_gnt", 64'(bus.wbs_gnt), 64'd1);
        chk("rstrd post core_rvalid", 64'(bus.core_rvalid), 64'd0);
        tick();
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
